// File: rtl/mux_scan_ctrl.sv
// Round-robin select sequencer for mux4_1: grants d0..d3 in turn, holds each for DWELL cycles.
// Define MUX_SCAN_SKIP_EN to skip channels whose req bit is low; otherwise req is ignored.
module mux_scan_ctrl #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CW    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic       s1,
  output logic       s0,
  output logic       valid,
  output logic       done,
  output logic       busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

  logic [0:0]    r_state;
  logic [1:0]    r_sel;
  logic [1:0]    r_last;
  logic [CW-1:0] r_cnt;
  logic          r_valid;
  logic          r_done;

  logic [1:0]    w_cand;
  logic          w_found;
  logic          w_grant;

`ifdef MUX_SCAN_SKIP_EN
  logic [1:0]    w_idx;

  // The current holder is visited last (offset 4), so it only wins as sole requester.
  always_comb begin
    w_cand  = r_last + 2'd1;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      w_idx = r_last + 2'(k);
      if (!w_found && req[w_idx]) begin
        w_cand  = w_idx;
        w_found = 1'b1;
      end
    end
  end
`else
  logic w_unused_req;
  assign w_unused_req = ^req;

  always_comb begin
    w_cand  = r_last + 2'd1;
    w_found = 1'b1;
  end
`endif

  assign w_grant = en & w_found;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_last  <= 2'd3;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_state <= ST_HOLD;
            r_sel   <= w_cand;
            r_last  <= w_cand;
            r_cnt   <= RELOAD;
            r_valid <= 1'b1;
            r_done  <= (RELOAD == '0);
          end
        end
        default: begin
          if (r_cnt != '0) begin
            r_cnt  <= r_cnt - 1'b1;
            r_done <= (r_cnt == CW'(1));
          end else if (w_grant) begin
            r_sel  <= w_cand;
            r_last <= w_cand;
            r_cnt  <= RELOAD;
            r_done <= (RELOAD == '0);
          end else begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign s1    = r_sel[1];
  assign s0    = r_sel[0];
  assign valid = r_valid;
  assign done  = r_done;
  assign busy  = r_valid;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Randomized bench for mux_scan_ctrl: four instances (DWELL 4, 2, 1, and 16 with CW=4)
// compared every cycle against a grant/remaining-cycles reference model.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [3:0] req = 4'hF;

  logic [3:0] o_s1, o_s0, o_valid, o_done, o_busy;

  int unsigned n_checks   = 0;
  int unsigned n_failures = 0;

  always #5 clk = ~clk;

  mux_scan_ctrl #(.DWELL(4), .CW(8)) u_d4 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .s1(o_s1[0]), .s0(o_s0[0]), .valid(o_valid[0]), .done(o_done[0]), .busy(o_busy[0]));
  mux_scan_ctrl #(.DWELL(2), .CW(8)) u_d2 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .s1(o_s1[1]), .s0(o_s0[1]), .valid(o_valid[1]), .done(o_done[1]), .busy(o_busy[1]));
  mux_scan_ctrl #(.DWELL(1), .CW(8)) u_d1 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .s1(o_s1[2]), .s0(o_s0[2]), .valid(o_valid[2]), .done(o_done[2]), .busy(o_busy[2]));
  mux_scan_ctrl #(.DWELL(16), .CW(4)) u_d16 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .s1(o_s1[3]), .s0(o_s0[3]), .valid(o_valid[3]), .done(o_done[3]), .busy(o_busy[3]));

  // Reference model: whether a grant is live, its channel, and cycles left including this one.
  int unsigned dw     [4] = '{4, 2, 1, 16};
  bit          m_hold [4];
  int unsigned m_ch   [4];
  int unsigned m_rem  [4];
  int unsigned m_last [4];

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_hold[i] = 1'b0;
      m_ch[i]   = 0;
      m_rem[i]  = 0;
      m_last[i] = 3;
    end
  endtask

  task automatic model_edge(input bit r, input bit e, input logic [3:0] q);
    int unsigned c;
    bit          found;
    if (r) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 4; i++) begin
      if (m_hold[i] && m_rem[i] > 1) begin
        m_rem[i]--;
      end else begin
        found = 1'b0;
        c     = 0;
        for (int k = 1; k <= 4; k++) begin
`ifdef MUX_SCAN_SKIP_EN
          if (!found && q[(m_last[i] + k) % 4]) begin
`else
          if (!found) begin
`endif
            c     = (m_last[i] + k) % 4;
            found = 1'b1;
          end
        end
        if (e && found) begin
          m_hold[i] = 1'b1;
          m_ch[i]   = c;
          m_last[i] = c;
          m_rem[i]  = dw[i];
        end else begin
          m_hold[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("sel[%0d]", i),   {o_s1[i], o_s0[i]}, m_ch[i]);
      check($sformatf("valid[%0d]", i), o_valid[i], m_hold[i]);
      check($sformatf("done[%0d]", i),  o_done[i], (m_hold[i] && m_rem[i] == 1) ? 1 : 0);
      check($sformatf("busy[%0d]", i),  o_busy[i], m_hold[i]);
    end
  endtask

  task automatic step(input bit r, input bit e, input logic [3:0] q);
    rst = r;
    en  = e;
    req = q;
    @(posedge clk);
    model_edge(r, e, q);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    model_reset();
    step(1'b1, 1'b1, 4'hF);
    step(1'b1, 1'b1, 4'hF);
    // Full scan with every channel requesting.
    for (int n = 0; n < 24; n++) step(1'b0, 1'b1, 4'hF);
    // en dropped briefly, then held low so grants drain to idle, then resumed.
    step(1'b0, 1'b0, 4'hF);
    for (int n = 0; n < 20; n++) step(1'b0, 1'b0, 4'hF);
    for (int n = 0; n < 10; n++) step(1'b0, 1'b1, 4'hF);
    // Reset mid-dwell, then restart from channel 0.
    step(1'b1, 1'b1, 4'hF);
    for (int n = 0; n < 12; n++) step(1'b0, 1'b1, 4'h5);
    for (int n = 0; n < 40; n++) step(1'b0, 1'b1, 4'h8);
    for (int n = 0; n < 10; n++) step(1'b0, 1'b1, 4'h0);
    // Random traffic with occasional reset and en gaps.
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, 4'($urandom_range(0, 15)));
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Registered select sequencer that drives the s1/s0 select lines of the mux4_1 data selector. It walks the four mux inputs d0–d3 in round-robin order and holds each selection for a programmable dwell time. It flags when the mux output y carries a granted channel, and pulses once at the end of each dwell. It sits directly upstream of mux4_1, and its s1/s0 connect straight to the mux select pins.

## Interface
- DWELL, default 4: cycles each granted channel stays selected; legal range 1..2^CW.
- CW, default 8: width of the dwell counter.

- clk  in  1  rising-edge clock for all state.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- en  in  1  allows new grants; does not abort a dwell in progress.
- req  in  4  per-channel request; bit i corresponds to mux input di.
- s1  out  1  select MSB to mux4_1.
- s0  out  1  select LSB to mux4_1.
- valid  out  1  high while a granted channel is selected; y is meaningful only then.
- done  out  1  one-cycle pulse during the last dwell cycle of each grant.
- busy  out  1  FSM in HOLD; equals valid.

## Operation
- Internal state:
  - FSM with two states, IDLE and HOLD.
  - 2-bit sel, driving s1 = sel[1] and s0 = sel[0].
  - 2-bit last pointer, the last granted channel.
  - CW-bit down-counter cnt.
- Reset values: FSM = IDLE, sel = 00, last = 3, cnt = 0, valid = 0, done = 0, busy = 0.
- Grant condition (G): en == 1, and a candidate exists.
- Candidate search: check channels last+1, last+2, last+3, last+4 (mod 4), in that order; take the first one whose req bit is 1.
- IDLE:
  - If G holds: load sel = candidate, last = candidate, cnt = DWELL−1, valid = 1, and go to HOLD.
  - Otherwise: stay in IDLE; sel keeps its previous value.
- HOLD:
  - Each cycle, cnt decrements while cnt != 0.
  - done = 1 in the cycle where cnt == 0.
  - At the end of that cycle, if G holds, regrant back-to-back: new sel, cnt reloads, remain in HOLD, no bubble.
  - Otherwise, go to IDLE: valid = 0 and sel holds.
- Dropping en or a req bit mid-dwell has no effect; the current dwell always completes.
- The current holder may be regranted only if it is the sole requester, because it is searched last (last+4).
- rst mid-dwell: all state returns to reset values on the next edge, so the next grant prefers ch0.
- Arithmetic: cnt is unsigned; DWELL−1 is truncated to CW bits. DWELL = 0 is illegal and its behaviour is undefined.

## Timing
- All outputs are registered and change only on rising clk edges.
- Grant latency: 1 cycle. G sampled at edge N gives s1/s0/valid updated after edge N.
- y from mux4_1 is combinational and is valid in the same cycles as valid.
- Each grant occupies exactly DWELL cycles of valid = 1.
- done is high in the DWELL-th cycle of each grant. With DWELL = 1, done is high in every grant cycle.
- Back-to-back grants: valid stays continuously high; sel changes on the edge immediately after done.

## Configuration
- MUX_SCAN_SKIP_EN defined:
  - Candidate search honours req, as described in Operation, so channels with no request are skipped.
- MUX_SCAN_SKIP_EN undefined:
  - req is ignored; the candidate is always last+1 (mod 4).
  - G reduces to en == 1, so the sequencer scans 0,1,2,3,0,… unconditionally.
  - Port list is unchanged.

## Test plan
- Reset: rst = 1 for 2 cycles with req = 1111 and en = 1 → s1s0 = 00, valid = 0, done = 0, busy = 0.
- Full scan, DWELL = 4, en = 1, req = 1111 → after 1 cycle of latency, sel is 0,1,2,3,0, each held 4 cycles; valid stays 1; done is high every 4th cycle.
- Sparse requests, req = 0101, DWELL = 2:
  - With MUX_SCAN_SKIP_EN → sel 0,2,0,2.
  - Without the macro → sel 0,1,2,3.
- en dropped in the 2nd cycle of ch1 with req = 1111 → ch1 completes 4 cycles, then valid = 0 and s1s0 holds 01. When en returns, the next grant is ch2 with 1-cycle latency.
- rst pulsed in the 3rd cycle of ch2 → after the edge, outputs take reset values; with en = 1 and req = 1111 after rst deasserts, the next grant is ch0.
- DWELL = 1, req = 1000 with MUX_SCAN_SKIP_EN → sel stays 11 (ch3 regranted), valid and done both continuously 1.
